// File: rtl/fifo_ctrl_master_rw_pkg.sv
// Shared definitions for the FIFO-fronted burst master: arbiter state encoding
// and default burst geometry.
package fifo_ctrl_master_rw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_WAIT = 2'd1,
        ST_RD_WAIT = 2'd2
    } state_t;

    localparam int         DEF_FIFO_DEPTH = 1024;
    localparam logic [7:0] DEF_WBURST_LEN = 8'd128;
    localparam logic [7:0] DEF_RBURST_LEN = 8'd128;
    localparam int         DEF_ADDR_INC   = 2;

    // Address units covered by one burst.
    function automatic int burst_step(input logic [7:0] len, input int inc);
        return int'(len) * inc;
    endfunction

endpackage

// File: rtl/fifo_ctrl_master_rw_sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count and sticky overflow flag.
// The head word is held in a read register so the array maps onto block RAM.
module fifo_ctrl_master_rw_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_ptr_next;
    logic [AW:0]      count_reg;
    logic             ovf_reg;
    logic [WIDTH-1:0] dout_reg;
    logic             full;
    logic             empty;
    logic             push_ok;
    logic             pop_ok;

    assign full        = (count_reg == (AW+1)'(DEPTH));
    assign empty       = (count_reg == '0);
    assign push_ok     = push && !full;
    assign pop_ok      = pop && !empty;
    assign rd_ptr_next = pop_ok ? rd_ptr_reg + 1'b1 : rd_ptr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            rd_ptr_reg <= rd_ptr_next;
            if (push_ok && !pop_ok)      count_reg <= count_reg + 1'b1;
            else if (!push_ok && pop_ok) count_reg <= count_reg - 1'b1;
            if (push && full) ovf_reg <= 1'b1;
        end
    end

    // Fetch the next head word; bypass the array when it is being written now.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg] <= din;
        if (push_ok && (wr_ptr_reg == rd_ptr_next)) dout_reg <= din;
        else                                          dout_reg <= mem[rd_ptr_next];
    end

    assign dout  = dout_reg;
    assign count = count_reg;
    assign ovf   = ovf_reg;

endmodule

// File: rtl/fifo_ctrl_master_rw.sv
// Burst master between user FIFOs and a burst bus: round-robin arbitration of
// write-drain and read-prefetch bursts over two address rings.
module fifo_ctrl_master_rw
    import fifo_ctrl_master_rw_pkg::*;
#(
    parameter int         ADDR_WIDTH = 26,
    parameter int         DATA_WIDTH = 32,
    parameter int         FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter logic [7:0] WBURST_LEN = DEF_WBURST_LEN,
    parameter logic [7:0] RBURST_LEN = DEF_RBURST_LEN,
    parameter int         ADDR_INC   = DEF_ADDR_INC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] usr_wr_begin_addr,
    input  logic [ADDR_WIDTH-1:0] usr_wr_end_addr,
    input  logic [ADDR_WIDTH-1:0] usr_rd_begin_addr,
    input  logic [ADDR_WIDTH-1:0] usr_rd_end_addr,
    input  logic                  usr_wr_en,
    input  logic [DATA_WIDTH-1:0] usr_wr_data,
    output logic                  usr_wr_full,
    input  logic                  usr_rd_en,
    output logic [DATA_WIDTH-1:0] usr_rd_data,
    output logic                  usr_rd_empty,
    input  logic                  rd_enable,
    input  logic                  wr_fifo_rd_en,
    output logic [DATA_WIDTH-1:0] wr_fifo_dout,
    input  logic                  wr_ready,
    output logic                  wr_trig,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [7:0]            wr_burst_len,
    input  logic                  wr_done,
    input  logic                  rd_fifo_wr_en,
    input  logic [DATA_WIDTH-1:0] rd_fifo_din,
    input  logic                  rd_ready,
    output logic                  rd_trig,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [7:0]            rd_burst_len,
    input  logic                  rd_done,
    output logic                  wr_ovf,
    output logic                  rd_ovf
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    // Two guard bits so the look-ahead sum (next + step) cannot wrap.
    localparam int XW = ADDR_WIDTH + 2;
    localparam logic [XW-1:0] WSTEP = XW'(burst_step(WBURST_LEN, ADDR_INC));
    localparam logic [XW-1:0] RSTEP = XW'(burst_step(RBURST_LEN, ADDR_INC));

    logic [CW-1:0]         wr_cnt;
    logic [CW-1:0]         rd_cnt;
    logic [CW-1:0]         rd_outstanding;
    logic                  wr_elig;
    logic                  rd_elig;
    logic [XW-1:0]         wr_next_x;
    logic [XW-1:0]         rd_next_x;
    logic [ADDR_WIDTH-1:0] wr_wrap_addr;
    logic [ADDR_WIDTH-1:0] rd_wrap_addr;

    state_t                state_reg, state_next;
    logic                  wr_trig_reg, wr_trig_next;
    logic                  rd_trig_reg, rd_trig_next;
    logic                  last_wr_reg, last_wr_next;
    logic [ADDR_WIDTH-1:0] wr_addr_reg, wr_addr_next;
    logic [ADDR_WIDTH-1:0] rd_addr_reg, rd_addr_next;

    fifo_ctrl_master_rw_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (usr_wr_en),
        .din   (usr_wr_data),
        .pop   (wr_fifo_rd_en),
        .dout  (wr_fifo_dout),
        .count (wr_cnt),
        .ovf   (wr_ovf)
    );

    fifo_ctrl_master_rw_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rd_fifo_wr_en),
        .din   (rd_fifo_din),
        .pop   (usr_rd_en),
        .dout  (usr_rd_data),
        .count (rd_cnt),
        .ovf   (rd_ovf)
    );

    assign usr_wr_full  = (wr_cnt == CW'(FIFO_DEPTH));
    assign usr_rd_empty = (rd_cnt == '0);

    assign rd_outstanding = (state_reg == ST_RD_WAIT) ? CW'(RBURST_LEN) : '0;
    assign wr_elig = (wr_cnt >= CW'(WBURST_LEN)) && wr_ready;
    assign rd_elig = rd_enable && rd_ready &&
                     ((FIFO_DEPTH - int'(rd_cnt) - int'(rd_outstanding)) >= int'(RBURST_LEN));

    // Wrap early when the following burst would run past the exclusive end.
    assign wr_next_x    = {2'b00, wr_addr_reg} + WSTEP;
    assign rd_next_x    = {2'b00, rd_addr_reg} + RSTEP;
    assign wr_wrap_addr = ((wr_next_x + WSTEP) > {2'b00, usr_wr_end_addr}) ?
                          usr_wr_begin_addr : wr_next_x[ADDR_WIDTH-1:0];
    assign rd_wrap_addr = ((rd_next_x + RSTEP) > {2'b00, usr_rd_end_addr}) ?
                          usr_rd_begin_addr : rd_next_x[ADDR_WIDTH-1:0];

    always_comb begin
        state_next   = state_reg;
        wr_trig_next = 1'b0;
        rd_trig_next = 1'b0;
        last_wr_next = last_wr_reg;
        wr_addr_next = wr_addr_reg;
        rd_addr_next = rd_addr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (wr_elig && (!rd_elig || !last_wr_reg)) begin
                    state_next   = ST_WR_WAIT;
                    wr_trig_next = 1'b1;
                    last_wr_next = 1'b1;
                end else if (rd_elig) begin
                    state_next   = ST_RD_WAIT;
                    rd_trig_next = 1'b1;
                    last_wr_next = 1'b0;
                end
            end
            ST_WR_WAIT: begin
                if (wr_done) begin
                    wr_addr_next = wr_wrap_addr;
                    state_next   = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                if (rd_done) begin
                    rd_addr_next = rd_wrap_addr;
                    state_next   = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            wr_trig_reg <= 1'b0;
            rd_trig_reg <= 1'b0;
            last_wr_reg <= 1'b0;
            wr_addr_reg <= usr_wr_begin_addr;
            rd_addr_reg <= usr_rd_begin_addr;
        end else begin
            state_reg   <= state_next;
            wr_trig_reg <= wr_trig_next;
            rd_trig_reg <= rd_trig_next;
            last_wr_reg <= last_wr_next;
            wr_addr_reg <= wr_addr_next;
            rd_addr_reg <= rd_addr_next;
        end
    end

    assign wr_trig      = wr_trig_reg;
    assign rd_trig      = rd_trig_reg;
    assign wr_addr      = wr_addr_reg;
    assign rd_addr      = rd_addr_reg;
    assign wr_burst_len = WBURST_LEN;
    assign rd_burst_len = RBURST_LEN;

endmodule
